// File: rtl/sprite_pkg.sv
// Shared defaults for the sprite compositor: coordinate/colour widths and fixed colours.
package sprite_pkg;

    localparam int unsigned COORD_W = 10;
    localparam int unsigned COLOR_W = 12;

    localparam logic [COLOR_W-1:0] BG_COLOR    = 12'h111;
    localparam logic [COLOR_W-1:0] COLOR_BLACK = '0;

endpackage : sprite_pkg

// File: rtl/sprite_hit.sv
// Combinational strict-bounds rectangle test for one object.
// Right/bottom edges are summed one bit wider, so an object near the edge never wraps to 0.
module sprite_hit #(
    parameter int unsigned COORD_W = sprite_pkg::COORD_W
) (
    input  logic               en,
    input  logic [COORD_W-1:0] obj_x,
    input  logic [COORD_W-1:0] obj_y,
    input  logic [COORD_W-1:0] obj_w,
    input  logic [COORD_W-1:0] obj_h,
    input  logic [COORD_W-1:0] x_pix,
    input  logic [COORD_W-1:0] y_pix,
    output logic               hit_c
);

    localparam int unsigned SUM_W = COORD_W + 1;

    logic [SUM_W-1:0] x_end;
    logic [SUM_W-1:0] y_end;
    logic             in_x;
    logic             in_y;

    assign x_end = SUM_W'(obj_x) + SUM_W'(obj_w);
    assign y_end = SUM_W'(obj_y) + SUM_W'(obj_h);

    // Strict on both sides: w or h of 0 or 1 leaves no pixel inside.
    assign in_x = (x_pix > obj_x) && (SUM_W'(x_pix) < x_end);
    assign in_y = (y_pix > obj_y) && (SUM_W'(y_pix) < y_end);

    assign hit_c = en && in_x && in_y;

endmodule : sprite_hit

// File: rtl/sprite_compositor.sv
// Per-pixel renderer for N_OBJ prioritised rectangles with a 2-beat pixel pipeline.
// Optional per-frame collision flags are built when SPRITE_COLLISION_EN is defined.
module sprite_compositor #(
    parameter int unsigned         N_OBJ    = 4,
    parameter int unsigned         COORD_W  = sprite_pkg::COORD_W,
    parameter int unsigned         COLOR_W  = sprite_pkg::COLOR_W,
    parameter logic [COLOR_W-1:0]  BG_COLOR = COLOR_W'(sprite_pkg::BG_COLOR)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       pix_en,
    input  logic [COORD_W-1:0]         x_pix,
    input  logic [COORD_W-1:0]         y_pix,
    input  logic                       visible,
    input  logic                       frame_start,
    input  logic [N_OBJ*COORD_W-1:0]   obj_x,
    input  logic [N_OBJ*COORD_W-1:0]   obj_y,
    input  logic [N_OBJ*COORD_W-1:0]   obj_w,
    input  logic [N_OBJ*COORD_W-1:0]   obj_h,
    input  logic [N_OBJ*COLOR_W-1:0]   obj_color,
    input  logic [N_OBJ-1:0]           obj_en,
    output logic [COLOR_W-1:0]         pixel_color,
    output logic                       pixel_valid,
    output logic [N_OBJ-1:0]           coll_flags,
    output logic                       coll_valid
);

    import sprite_pkg::*;

    logic [N_OBJ*COORD_W-1:0] act_x;
    logic [N_OBJ*COORD_W-1:0] act_y;
    logic [N_OBJ*COORD_W-1:0] act_w;
    logic [N_OBJ*COORD_W-1:0] act_h;
    logic [N_OBJ*COLOR_W-1:0] act_color;
    logic [N_OBJ-1:0]         act_en;

    logic [N_OBJ-1:0]         hit_c;
    logic [N_OBJ-1:0]         hit_q;
    logic                     vis_q;
    logic [COLOR_W-1:0]       sel_color_c;
    logic [COLOR_W-1:0]       pix_next_c;

    // Active set: frozen between frame_start beats so a frame never tears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_x     <= '0;
            act_y     <= '0;
            act_w     <= '0;
            act_h     <= '0;
            act_color <= '0;
            act_en    <= '0;
        end else if (pix_en && frame_start) begin
            act_x     <= obj_x;
            act_y     <= obj_y;
            act_w     <= obj_w;
            act_h     <= obj_h;
            act_color <= obj_color;
            act_en    <= obj_en;
        end
    end

    for (genvar i = 0; i < N_OBJ; i++) begin : g_hit
        sprite_hit #(
            .COORD_W (COORD_W)
        ) u_hit (
            .en    (act_en[i]),
            .obj_x (act_x[i*COORD_W +: COORD_W]),
            .obj_y (act_y[i*COORD_W +: COORD_W]),
            .obj_w (act_w[i*COORD_W +: COORD_W]),
            .obj_h (act_h[i*COORD_W +: COORD_W]),
            .x_pix (x_pix),
            .y_pix (y_pix),
            .hit_c (hit_c[i])
        );
    end

    // Stage 1: hit vector and visibility.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_q <= '0;
            vis_q <= 1'b0;
        end else if (pix_en) begin
            hit_q <= hit_c;
            vis_q <= visible;
        end
    end

    // Lowest index wins: scan from the top so lower indices overwrite.
    always_comb begin
        sel_color_c = BG_COLOR;
        for (int i = int'(N_OBJ) - 1; i >= 0; i--) begin
            if (hit_q[i]) begin
                sel_color_c = act_color[i*COLOR_W +: COLOR_W];
            end
        end
    end

    assign pix_next_c = vis_q ? sel_color_c : COLOR_W'(COLOR_BLACK);

    // Stage 2: output colour and valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_color <= '0;
            pixel_valid <= 1'b0;
        end else if (pix_en) begin
            pixel_color <= pix_next_c;
            pixel_valid <= vis_q;
        end
    end

`ifdef SPRITE_COLLISION_EN
    logic [N_OBJ-1:0] acc;
    logic             multi_c;

    assign multi_c = ($countones(hit_c) >= 2);

    // Overlaps accumulate over the frame and publish at the next frame_start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc        <= '0;
            coll_flags <= '0;
            coll_valid <= 1'b0;
        end else begin
            coll_valid <= 1'b0;
            if (pix_en) begin
                if (frame_start) begin
                    coll_flags <= acc;
                    acc        <= '0;
                    coll_valid <= 1'b1;
                end else if (visible && multi_c) begin
                    acc <= acc | hit_c;
                end
            end
        end
    end
`else
    assign coll_flags = '0;
    assign coll_valid = 1'b0;
`endif

endmodule : sprite_compositor

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor; collision expectations follow SPRITE_COLLISION_EN.
module tb_sprite_compositor;

    localparam int unsigned N_OBJ = 4;
    localparam int unsigned CW    = 10;
    localparam int unsigned LW    = 12;
`ifdef SPRITE_COLLISION_EN
    localparam bit COLL = 1'b1;
`else
    localparam bit COLL = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   pix_en;
    logic [CW-1:0]          x_pix;
    logic [CW-1:0]          y_pix;
    logic                   visible;
    logic                   frame_start;
    logic [N_OBJ*CW-1:0]    obj_x;
    logic [N_OBJ*CW-1:0]    obj_y;
    logic [N_OBJ*CW-1:0]    obj_w;
    logic [N_OBJ*CW-1:0]    obj_h;
    logic [N_OBJ*LW-1:0]    obj_color;
    logic [N_OBJ-1:0]       obj_en;
    logic [LW-1:0]          pixel_color;
    logic                   pixel_valid;
    logic [N_OBJ-1:0]       coll_flags;
    logic                   coll_valid;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic [CW-1:0] xs   [6] = '{10'd99, 10'd100, 10'd101, 10'd115, 10'd129, 10'd130};
    logic [LW-1:0] exps [6] = '{12'h111, 12'h111, 12'hFFF, 12'hFFF, 12'hFFF, 12'h111};

    always #5 clk = ~clk;

    sprite_compositor u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pix_en      (pix_en),
        .x_pix       (x_pix),
        .y_pix       (y_pix),
        .visible     (visible),
        .frame_start (frame_start),
        .obj_x       (obj_x),
        .obj_y       (obj_y),
        .obj_w       (obj_w),
        .obj_h       (obj_h),
        .obj_color   (obj_color),
        .obj_en      (obj_en),
        .pixel_color (pixel_color),
        .pixel_valid (pixel_valid),
        .coll_flags  (coll_flags),
        .coll_valid  (coll_valid)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [CW-1:0] x, input logic [CW-1:0] y, input logic vis);
        x_pix   = x;
        y_pix   = y;
        visible = vis;
        pix_en  = 1'b1;
        tick();
    endtask

    task automatic probe(input logic [CW-1:0] x, input logic [CW-1:0] y,
                         output logic [LW-1:0] col, output logic vld);
        beat(x, y, 1'b1);
        beat('0, '0, 1'b0);
        col = pixel_color;
        vld = pixel_valid;
    endtask

    task automatic probe_chk(input string tag, input logic [CW-1:0] x, input logic [CW-1:0] y,
                             input logic [LW-1:0] exp);
        logic [LW-1:0] col;
        logic          vld;
        probe(x, y, col, vld);
        check(tag, 32'(col), 32'(exp));
    endtask

    task automatic set_obj(input int i, input logic [CW-1:0] x, input logic [CW-1:0] y,
                           input logic [CW-1:0] w, input logic [CW-1:0] h,
                           input logic [LW-1:0] col, input logic en);
        obj_x[i*CW +: CW]     = x;
        obj_y[i*CW +: CW]     = y;
        obj_w[i*CW +: CW]     = w;
        obj_h[i*CW +: CW]     = h;
        obj_color[i*LW +: LW] = col;
        obj_en[i]             = en;
    endtask

    task automatic frame();
        frame_start = 1'b1;
        visible     = 1'b0;
        pix_en      = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    // Row y=110 through object 0 at x=100,w=30; optional idle cycle after each beat.
    task automatic stream(input string tag, input bit toggle);
        for (int i = 0; i < 7; i++) begin
            if (i < 6) beat(xs[i], 10'd110, 1'b1);
            else       beat('0, 10'd110, 1'b0);
            if (i >= 1) begin
                check({tag, "_col"}, 32'(pixel_color), 32'(exps[i-1]));
                check({tag, "_vld"}, 32'(pixel_valid), 32'd1);
            end
            if (toggle) begin
                pix_en  = 1'b0;
                x_pix   = CW'($urandom);
                visible = 1'b1;
                tick();
                if (i >= 1) check({tag, "_hold"}, 32'(pixel_color), 32'(exps[i-1]));
            end
        end
    endtask

    initial begin
        logic [LW-1:0] col;
        logic          vld;
        int unsigned   bad;
        int unsigned   nvalid;
        bit            cv_seen;

        rst_n = 1'b0; pix_en = 1'b0; x_pix = '0; y_pix = '0; visible = 1'b0;
        frame_start = 1'b0; obj_x = '0; obj_y = '0; obj_w = '0; obj_h = '0;
        obj_color = '0; obj_en = '0;
        repeat (3) tick();
        check("rst_color", 32'(pixel_color), 32'd0);
        check("rst_valid", 32'(pixel_valid), 32'd0);
        check("rst_cflags", 32'(coll_flags), 32'd0);
        check("rst_cvalid", 32'(coll_valid), 32'd0);
        rst_n = 1'b1;
        tick();

        // Background sweep with no frame_start yet; the active set is empty.
        bad = 0; nvalid = 0; cv_seen = 1'b0;
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 642; x++) begin
                beat(CW'(x < 640 ? x : 0), CW'(y), x < 640);
                if (pixel_valid) begin
                    nvalid++;
                    if (pixel_color !== 12'h111) bad++;
                end
                if (coll_valid) cv_seen = 1'b1;
            end
        end
        check("sweep_bg", bad, 0);
        check("sweep_nvalid", nvalid, 4 * 640);
        check("sweep_cv", 32'(cv_seen), 32'd0);

        set_obj(0, 10'd100, 10'd100, 10'd30, 10'd30, 12'hFFF, 1'b1);
        frame();
        check("first_cflags", 32'(coll_flags), 32'd0);
        check("first_cvalid", 32'(coll_valid), 32'(COLL));
        stream("edge", 1'b0);
        probe_chk("top_out", 10'd110, 10'd100, 12'h111);
        probe_chk("top_in", 10'd110, 10'd101, 12'hFFF);
        probe_chk("bot_in", 10'd110, 10'd129, 12'hFFF);
        probe_chk("bot_out", 10'd110, 10'd130, 12'h111);
        probe(10'd110, 10'd110, col, vld);
        check("vis_on_valid", 32'(vld), 32'd1);
        beat(10'd110, 10'd110, 1'b0);
        beat('0, '0, 1'b0);
        check("vis_off_color", 32'(pixel_color), 32'd0);
        check("vis_off_valid", 32'(pixel_valid), 32'd0);

        stream("toggle", 1'b1);

        // Overlapping pair: priority and collision flags.
        set_obj(0, 10'd100, 10'd100, 10'd30, 10'd30, 12'hF00, 1'b1);
        set_obj(1, 10'd105, 10'd105, 10'd30, 10'd30, 12'h0F0, 1'b1);
        frame();
        probe_chk("prio_overlap", 10'd110, 10'd110, 12'hF00);
        probe_chk("obj1_only", 10'd132, 10'd132, 12'h0F0);
        frame();
        check("coll_flags", 32'(coll_flags), COLL ? 32'h3 : 32'h0);
        check("coll_pulse", 32'(coll_valid), 32'(COLL));
        pix_en = 1'b0;
        tick();
        check("coll_pulse_end", 32'(coll_valid), 32'd0);
        probe_chk("no_overlap", 10'd115, 10'd200, 12'h111);
        frame();
        check("coll_clear", 32'(coll_flags), 32'd0);

        // Shadow change without frame_start must not show until the next frame.
        set_obj(0, 10'd300, 10'd100, 10'd30, 10'd30, 12'hF00, 1'b1);
        probe_chk("shadow_old", 10'd110, 10'd110, 12'hF00);
        probe_chk("shadow_old_new", 10'd310, 10'd110, 12'h111);
        frame();
        probe_chk("shadow_new_old", 10'd110, 10'd110, 12'h0F0);
        probe_chk("shadow_new", 10'd310, 10'd110, 12'hF00);

        // Right-edge object must not wrap; 1-wide object is empty.
        set_obj(0, '0, '0, '0, '0, '0, 1'b0);
        set_obj(1, '0, '0, '0, '0, '0, 1'b0);
        set_obj(2, 10'd1000, 10'd0, 10'd100, 10'd500, 12'h00F, 1'b1);
        set_obj(3, 10'd200, 10'd0, 10'd1, 10'd50, 12'hABC, 1'b1);
        frame();
        probe_chk("wrap_1000", 10'd1000, 10'd10, 12'h111);
        probe_chk("wrap_1001", 10'd1001, 10'd10, 12'h00F);
        probe_chk("wrap_1023", 10'd1023, 10'd10, 12'h00F);
        probe_chk("wrap_0", 10'd0, 10'd10, 12'h111);
        probe_chk("wrap_50", 10'd50, 10'd10, 12'h111);
        probe_chk("w1_200", 10'd200, 10'd10, 12'h111);
        probe_chk("w1_201", 10'd201, 10'd10, 12'h111);

        // Asynchronous reset mid-line.
        beat(10'd1005, 10'd10, 1'b1);
        beat(10'd1006, 10'd10, 1'b1);
        check("pre_rst_color", 32'(pixel_color), 32'h00F);
        rst_n = 1'b0;
        #1;
        check("midrst_color", 32'(pixel_color), 32'd0);
        check("midrst_valid", 32'(pixel_valid), 32'd0);
        check("midrst_cflags", 32'(coll_flags), 32'd0);
        check("midrst_cvalid", 32'(coll_valid), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        probe(10'd1005, 10'd10, col, vld);
        check("post_rst_bg", 32'(col), 32'h111);
        check("post_rst_valid", 32'(vld), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_sprite_compositor
